// File: rtl/pinwheel_periph_pkg.sv
// Shared types and constants for the pinwheel debug/serial peripheral:
// TileLink-UL channel structs, opcodes, register offsets and STATUS layout.
package pinwheel_periph_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL    = 3'd0,
    TL_PUT_PARTIAL = 3'd1,
    TL_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
  } tilelink_d;

  // Byte offsets inside the selected tag window.
  localparam logic [7:0] PERIPH_OFF_DEBUG  = 8'h00;
  localparam logic [7:0] PERIPH_OFF_TX     = 8'h40;
  localparam logic [7:0] PERIPH_OFF_RX     = 8'h44;
  localparam logic [7:0] PERIPH_OFF_STATUS = 8'h48;

  // STATUS register bit positions.
  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_TX_OVF    = 1;
  localparam int STAT_RX_OVF    = 2;
  localparam int STAT_RX_IRQ_EN = 3;
  localparam int STAT_TX_COUNT  = 16;
  localparam int STAT_RX_COUNT  = 24;

endpackage

// File: rtl/pinwheel_periph_if.sv
// Core-bus attachment: request channel in, registered response channel out.
interface pinwheel_periph_if;
  import pinwheel_periph_pkg::*;

  tilelink_a tick_tla;
  tilelink_d bus_tld;

  modport master (output tick_tla, input bus_tld);
  modport slave  (input tick_tla, output bus_tld);
endinterface

// File: rtl/pinwheel_periph_sync_fifo.sv
// Single-clock FIFO with head-of-queue read port. A push into a full FIFO is
// accepted when a pop happens in the same cycle; pop on empty is ignored.
module pinwheel_periph_sync_fifo #(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic                   clock,
  input  logic                   tick_reset_in,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(depth):0] count
);
  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  logic [width-1:0] mem_r [depth];
  logic [ptr_w-1:0] wr_ptr_r;
  logic [ptr_w-1:0] rd_ptr_r;
  logic [cnt_w-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == cnt_w'(0));
  assign full      = (count_r == cnt_w'(depth));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers (wrapping modulo depth) and occupancy count.
  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= {width{1'b0}};
      end
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {cnt_w{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + ptr_w'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pinwheel_periph.sv
// TileLink-UL slave providing debug/scratch registers, buffered serial TX and
// RX channels, a STATUS/control register and an RX interrupt. Every selected
// request is answered exactly one cycle later; reads see pre-update state.
module pinwheel_periph
  import pinwheel_periph_pkg::*;
#(
  parameter logic [31:0] addr_mask = 32'hF000_0000,
  parameter logic [31:0] addr_tag  = 32'hF000_0000,
  parameter int          n_debug   = 4,
  parameter int          tx_depth  = 8,
  parameter int          rx_depth  = 8
) (
  input  logic              clock,
  input  logic              tick_reset_in,
  pinwheel_periph_if.slave  bus,
  output logic [7:0]        ser_tx_data,
  output logic              ser_tx_valid,
  input  logic              ser_tx_ready,
  input  logic [7:0]        ser_rx_data,
  input  logic              ser_rx_valid,
  output logic [31:0]       debug_out,
  output logic              irq
);
  localparam int tx_cnt_w = $clog2(tx_depth) + 1;
  localparam int rx_cnt_w = $clog2(rx_depth) + 1;

  tilelink_a     tla_s;
  tilelink_d     tld_next_s;
  tilelink_d     tld_r;
  logic          unused_s;

  logic          sel_s, is_get_s, is_put_s, in_page_s;
  logic [7:0]    byte_off_s;
  logic [3:0]    dbg_idx_s;
  logic          hit_dbg_s, hit_tx_s, hit_rx_s, hit_status_s, hit_s;
  logic          dbg_wr_s, status_wr_s;

  logic [31:0]   debug_r [n_debug];
  logic [31:0]   dbg_rdata_s, status_s, rdata_s;

  logic          tx_push_s, tx_pop_s, tx_empty_s, tx_full_s;
  logic [7:0]    tx_rdata_s;
  logic [tx_cnt_w-1:0] tx_count_s;
  logic          rx_pop_s, rx_empty_s, rx_full_s, rx_push_ok_s, rx_nonempty_next_s;
  logic [7:0]    rx_rdata_s;
  logic [rx_cnt_w-1:0] rx_count_s;

  logic          tx_ovf_r, rx_ovf_r, rx_irq_en_r, irq_r;
  logic          tx_ovf_set_s, rx_ovf_set_s, rx_irq_en_next_s;

  // Address decode: tag match, then word offset within the first 256 bytes.
  assign tla_s        = bus.tick_tla;
  assign unused_s     = ^{tla_s.a_param, tla_s.d_ready};
  assign sel_s        = tla_s.a_valid && ((tla_s.a_address & addr_mask) == addr_tag);
  assign is_get_s     = (tla_s.a_opcode == TL_GET);
  assign is_put_s     = !is_get_s;
  assign in_page_s    = ((tla_s.a_address & ~addr_mask & 32'hFFFF_FF00) == 32'h0000_0000);
  assign byte_off_s   = {tla_s.a_address[7:2], 2'b00};
  assign dbg_idx_s    = tla_s.a_address[5:2];
  assign hit_dbg_s    = in_page_s && (byte_off_s[7:6] == PERIPH_OFF_DEBUG[7:6])
                        && ({1'b0, dbg_idx_s} < 5'(n_debug));
  assign hit_tx_s     = in_page_s && (byte_off_s == PERIPH_OFF_TX);
  assign hit_rx_s     = in_page_s && (byte_off_s == PERIPH_OFF_RX);
  assign hit_status_s = in_page_s && (byte_off_s == PERIPH_OFF_STATUS);
  assign hit_s        = hit_dbg_s || hit_tx_s || hit_rx_s || hit_status_s;

  // Side-effect strobes.
  assign dbg_wr_s     = sel_s && is_put_s && hit_dbg_s;
  assign status_wr_s  = sel_s && is_put_s && hit_status_s;
  assign tx_push_s    = sel_s && is_put_s && hit_tx_s && tla_s.a_mask[0];
  assign tx_pop_s     = !tx_empty_s && ser_tx_ready;
  assign rx_pop_s     = sel_s && is_get_s && hit_rx_s && !rx_empty_s;
  assign tx_ovf_set_s = tx_push_s && tx_full_s && !tx_pop_s;
  assign rx_ovf_set_s = ser_rx_valid && rx_full_s && !rx_pop_s;
  assign rx_push_ok_s = ser_rx_valid && (!rx_full_s || rx_pop_s);

  // Next-cycle RX occupancy, so irq tracks the FIFO state it describes.
  assign rx_nonempty_next_s = rx_push_ok_s
                              || (rx_count_s > rx_cnt_w'(1))
                              || ((rx_count_s == rx_cnt_w'(1)) && !rx_pop_s);

  pinwheel_periph_sync_fifo #(.width(8), .depth(tx_depth)) u_tx_fifo (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .push          (tx_push_s),
    .wdata         (tla_s.a_data[7:0]),
    .pop           (tx_pop_s),
    .rdata         (tx_rdata_s),
    .empty         (tx_empty_s),
    .full          (tx_full_s),
    .count         (tx_count_s)
  );

  pinwheel_periph_sync_fifo #(.width(8), .depth(rx_depth)) u_rx_fifo (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .push          (ser_rx_valid),
    .wdata         (ser_rx_data),
    .pop           (rx_pop_s),
    .rdata         (rx_rdata_s),
    .empty         (rx_empty_s),
    .full          (rx_full_s),
    .count         (rx_count_s)
  );

  // Next value of the irq enable: a STATUS write loads bit 3.
  always_comb begin
    rx_irq_en_next_s = rx_irq_en_r;
    if (status_wr_s) begin
      rx_irq_en_next_s = tla_s.a_data[STAT_RX_IRQ_EN];
    end else begin
      rx_irq_en_next_s = rx_irq_en_r;
    end
  end

  // Select the addressed debug register (zero when the index matches none).
  always_comb begin
    dbg_rdata_s = 32'h0000_0000;
    for (int i = 0; i < n_debug; i++) begin
      dbg_rdata_s = dbg_rdata_s | ((dbg_idx_s == 4'(i)) ? debug_r[i] : 32'h0000_0000);
    end
  end

  // Assemble STATUS from current state.
  always_comb begin
    status_s                       = 32'h0000_0000;
    status_s[STAT_TX_FULL]         = tx_full_s;
    status_s[STAT_TX_OVF]          = tx_ovf_r;
    status_s[STAT_RX_OVF]          = rx_ovf_r;
    status_s[STAT_RX_IRQ_EN]       = rx_irq_en_r;
    status_s[STAT_TX_COUNT +: 8]   = 8'(tx_count_s);
    status_s[STAT_RX_COUNT +: 8]   = 8'(rx_count_s);
  end

  // Read-data mux; TX, unmapped offsets and Puts all read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!is_get_s) begin
      rdata_s = 32'h0000_0000;
    end else if (hit_dbg_s) begin
      rdata_s = dbg_rdata_s;
    end else if (hit_rx_s) begin
      rdata_s = rx_empty_s ? 32'h0000_0000 : {1'b1, 23'h00_0000, rx_rdata_s};
    end else if (hit_status_s) begin
      rdata_s = status_s;
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Build the response that will be presented in the following cycle.
  always_comb begin
    tld_next_s = '0;
    if (sel_s) begin
      tld_next_s.d_valid  = 1'b1;
      tld_next_s.d_opcode = is_get_s ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      tld_next_s.d_size   = tla_s.a_size;
      tld_next_s.d_source = tla_s.a_source;
      tld_next_s.d_data   = rdata_s;
      tld_next_s.d_error  = !hit_s;
    end else begin
      tld_next_s = '0;
    end
  end

  // Response register, sticky overflow flags (set beats clear), irq enable and irq.
  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      tld_r       <= '0;
      tx_ovf_r    <= 1'b0;
      rx_ovf_r    <= 1'b0;
      rx_irq_en_r <= 1'b0;
      irq_r       <= 1'b0;
    end else begin
      tld_r       <= tld_next_s;
      tx_ovf_r    <= tx_ovf_set_s ? 1'b1
                     : ((status_wr_s && tla_s.a_data[STAT_TX_OVF]) ? 1'b0 : tx_ovf_r);
      rx_ovf_r    <= rx_ovf_set_s ? 1'b1
                     : ((status_wr_s && tla_s.a_data[STAT_RX_OVF]) ? 1'b0 : rx_ovf_r);
      rx_irq_en_r <= rx_irq_en_next_s;
      irq_r       <= rx_irq_en_next_s && rx_nonempty_next_s;
    end
  end

  // Debug registers with per-byte write enables from a_mask.
  always_ff @(posedge clock) begin
    if (tick_reset_in) begin
      for (int i = 0; i < n_debug; i++) begin
        debug_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < n_debug; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (dbg_wr_s && (dbg_idx_s == 4'(i)) && tla_s.a_mask[b]) begin
            debug_r[i][8*b +: 8] <= tla_s.a_data[8*b +: 8];
          end
        end
      end
    end
  end

  assign bus.bus_tld   = tld_r;
  assign ser_tx_data   = tx_rdata_s;
  assign ser_tx_valid  = !tx_empty_s;
  assign debug_out     = debug_r[0];
  assign irq           = irq_r;

endmodule

// File: tb/tb_pinwheel_periph.sv
// Directed bench for pinwheel_periph: requests push their expected responses
// into a queue, and an independent monitor checks each response as it appears.
module tb_pinwheel_periph;
  import pinwheel_periph_pkg::*;

  logic        clock = 1'b0;
  logic        tick_reset_in = 1'b1;
  logic [7:0]  ser_tx_data;
  logic        ser_tx_valid;
  logic        ser_tx_ready = 1'b0;
  logic [7:0]  ser_rx_data = 8'h00;
  logic        ser_rx_valid = 1'b0;
  logic [31:0] debug_out;
  logic        irq;

  pinwheel_periph_if bus_if();

  pinwheel_periph dut (
    .clock         (clock),
    .tick_reset_in (tick_reset_in),
    .bus           (bus_if),
    .ser_tx_data   (ser_tx_data),
    .ser_tx_valid  (ser_tx_valid),
    .ser_tx_ready  (ser_tx_ready),
    .ser_rx_data   (ser_rx_data),
    .ser_rx_valid  (ser_rx_valid),
    .debug_out     (debug_out),
    .irq           (irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic        err;
    tl_d_op_e    op;
    logic [7:0]  src;
    int          due;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [7:0] src_ctr = 8'h00;
  logic       mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Issue one request for one cycle and queue its expected response.
  task automatic bus_req(input string name, input logic is_get, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data,
                         input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    bus_if.tick_tla           = '0;
    bus_if.tick_tla.a_valid   = 1'b1;
    bus_if.tick_tla.a_opcode  = is_get ? TL_GET : ((mask == 4'hF) ? TL_PUT_FULL : TL_PUT_PARTIAL);
    bus_if.tick_tla.a_size    = 2'd2;
    bus_if.tick_tla.a_source  = src_ctr;
    bus_if.tick_tla.a_address = addr;
    bus_if.tick_tla.a_mask    = mask;
    bus_if.tick_tla.a_data    = data;
    bus_if.tick_tla.d_ready   = 1'b1;
    e.data     = exp_data;
    e.chk_data = is_get;
    e.err      = exp_err;
    e.op       = is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    e.src      = src_ctr;
    e.due      = cyc + 1;
    e.name     = name;
    exp_q.push_back(e);
    src_ctr    = src_ctr + 8'h01;
    @(negedge clock);
    bus_if.tick_tla = '0;
  endtask

  task automatic get(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                     input logic exp_err);
    bus_req(name, 1'b1, addr, 4'hF, 32'h0, exp_data, exp_err);
  endtask

  task automatic put(input string name, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic exp_err);
    bus_req(name, 1'b0, addr, mask, data, 32'h0, exp_err);
  endtask

  // Response monitor: every d_valid must match the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (bus_if.bus_tld.d_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_d_valid", 32'h1, 32'h0);
          end else begin
            e = exp_q.pop_front();
            if (e.chk_data) chk({e.name, "_data"}, bus_if.bus_tld.d_data, e.data);
            chk({e.name, "_error"}, {31'h0, bus_if.bus_tld.d_error}, {31'h0, e.err});
            chk({e.name, "_opcode"}, 32'(bus_if.bus_tld.d_opcode), 32'(e.op));
            chk({e.name, "_source"}, {24'h0, bus_if.bus_tld.d_source}, {24'h0, e.src});
            chk({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          end
        end else begin
          chk("idle_d_data", bus_if.bus_tld.d_data, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    bus_if.tick_tla = '0;
    tick_reset_in   = 1'b1;
    repeat (3) tick();
    tick_reset_in = 1'b0;
    chk("reset_tx_valid", {31'h0, ser_tx_valid}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_debug_out", debug_out, 32'h0);
    chk("reset_d_valid", {31'h0, bus_if.bus_tld.d_valid}, 32'h0);
    mon_en = 1'b1;

    // Debug register byte-masked write and read-back.
    put("put_dbg1", 32'hF000_0004, 4'b0101, 32'hDEAD_BEEF, 1'b0);
    get("get_dbg1", 32'hF000_0004, 32'h00AD_00EF, 1'b0);
    put("put_dbg0", 32'hF000_0000, 4'hF, 32'h1234_5678, 1'b0);
    chk("debug_out", debug_out, 32'h1234_5678);
    get("get_status_idle", 32'hF000_0048, 32'h0000_0000, 1'b0);

    // TX fill past capacity with the consumer stalled.
    for (int i = 1; i <= 9; i++) begin
      put("put_tx", 32'hF000_0040, 4'h1, 32'(i), 1'b0);
      if (i == 1) begin
        chk("tx_valid_after_first", {31'h0, ser_tx_valid}, 32'h1);
        chk("tx_data_after_first", {24'h0, ser_tx_data}, 32'h01);
      end
    end
    get("get_status_txfull", 32'hF000_0048, 32'h0008_0003, 1'b0);
    get("get_tx_reads_zero", 32'hF000_0040, 32'h0000_0000, 1'b0);

    // Drain TX.
    ser_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", {31'h0, ser_tx_valid}, 32'h1);
      chk("drain_data", {24'h0, ser_tx_data}, 32'(k + 1));
      tick();
    end
    chk("drain_done_valid", {31'h0, ser_tx_valid}, 32'h0);
    ser_tx_ready = 1'b0;
    get("get_status_drained", 32'hF000_0048, 32'h0000_0002, 1'b0);

    // Enable RX irq, clear tx_ovf, then one RX byte.
    put("put_status_0a", 32'hF000_0048, 4'hF, 32'h0000_000A, 1'b0);
    get("get_status_en", 32'hF000_0048, 32'h0000_0008, 1'b0);
    chk("irq_before_rx", {31'h0, irq}, 32'h0);
    ser_rx_valid = 1'b1; ser_rx_data = 8'h5A;
    tick();
    ser_rx_valid = 1'b0;
    chk("irq_after_rx", {31'h0, irq}, 32'h1);
    get("get_rx_5a", 32'hF000_0044, 32'h8000_005A, 1'b0);
    chk("irq_after_pop", {31'h0, irq}, 32'h0);
    get("get_rx_empty", 32'hF000_0044, 32'h0000_0000, 1'b0);
    get("get_status_rx_empty", 32'hF000_0048, 32'h0000_0008, 1'b0);

    // RX full with simultaneous push and bus pop.
    for (int i = 0; i < 8; i++) begin
      ser_rx_valid = 1'b1; ser_rx_data = 8'(8'h10 + i);
      tick();
    end
    ser_rx_valid = 1'b1; ser_rx_data = 8'h77;
    get("get_rx_pop_push", 32'hF000_0044, 32'h8000_0010, 1'b0);
    ser_rx_valid = 1'b0;
    get("get_status_full_nov", 32'hF000_0048, 32'h0800_0008, 1'b0);
    for (int i = 1; i < 8; i++) begin
      get("get_rx_seq", 32'hF000_0044, 32'h8000_0010 + 32'(i), 1'b0);
    end
    get("get_rx_last_77", 32'hF000_0044, 32'h8000_0077, 1'b0);
    get("get_rx_empty2", 32'hF000_0044, 32'h0000_0000, 1'b0);

    // RX full with push and no pop: overflow; then set-beats-clear.
    for (int i = 0; i < 8; i++) begin
      ser_rx_valid = 1'b1; ser_rx_data = 8'(8'h20 + i);
      tick();
    end
    ser_rx_data = 8'h88;
    tick();
    ser_rx_valid = 1'b0;
    get("get_status_rx_ovf", 32'hF000_0048, 32'h0800_000C, 1'b0);
    ser_rx_valid = 1'b1; ser_rx_data = 8'h99;
    put("put_status_clr_race", 32'hF000_0048, 4'hF, 32'h0000_000C, 1'b0);
    ser_rx_valid = 1'b0;
    get("get_status_set_wins", 32'hF000_0048, 32'h0800_000C, 1'b0);
    chk("irq_rx_full", {31'h0, irq}, 32'h1);
    put("put_status_clr", 32'hF000_0048, 4'hF, 32'h0000_0004, 1'b0);
    chk("irq_disabled", {31'h0, irq}, 32'h0);
    get("get_status_cleared", 32'hF000_0048, 32'h0800_0000, 1'b0);
    get("get_rx_20", 32'hF000_0044, 32'h8000_0020, 1'b0);

    // Unmapped accesses.
    get("get_unmapped_100", 32'hF000_0100, 32'h0000_0000, 1'b1);
    get("get_dbg5", 32'hF000_0014, 32'h0000_0000, 1'b1);
    get("get_unmapped_4c", 32'hF000_004C, 32'h0000_0000, 1'b1);
    put("put_unmapped_50", 32'hF000_0050, 4'hF, 32'hFFFF_FFFF, 1'b1);
    put("put_dbg5", 32'hF000_0014, 4'hF, 32'hFFFF_FFFF, 1'b1);
    get("get_dbg1_unchanged", 32'hF000_0004, 32'h00AD_00EF, 1'b0);
    // Address outside the tag: no response is expected.
    bus_if.tick_tla.a_valid   = 1'b1;
    bus_if.tick_tla.a_opcode  = TL_GET;
    bus_if.tick_tla.a_address = 32'h0000_0040;
    tick();
    bus_if.tick_tla = '0;

    // Reset in the middle of a TX drain, with a request in the reset cycle.
    for (int i = 0; i < 4; i++) begin
      put("put_tx_a", 32'hF000_0040, 4'h1, 32'h0000_00A1 + 32'(i), 1'b0);
    end
    ser_tx_ready = 1'b1;
    chk("drain2_first", {24'h0, ser_tx_data}, 32'hA1);
    tick();
    chk("drain2_second", {24'h0, ser_tx_data}, 32'hA2);
    tick_reset_in             = 1'b1;
    bus_if.tick_tla.a_valid   = 1'b1;
    bus_if.tick_tla.a_opcode  = TL_GET;
    bus_if.tick_tla.a_address = 32'hF000_0048;
    tick();
    bus_if.tick_tla = '0;
    tick_reset_in   = 1'b0;
    ser_tx_ready    = 1'b0;
    chk("midreset_tx_valid", {31'h0, ser_tx_valid}, 32'h0);
    chk("midreset_debug_out", debug_out, 32'h0);
    chk("midreset_irq", {31'h0, irq}, 32'h0);
    get("get_status_after_reset", 32'hF000_0048, 32'h0000_0000, 1'b0);
    get("get_dbg1_after_reset", 32'hF000_0004, 32'h0000_0000, 1'b0);

    repeat (3) tick();
    chk("pending_responses", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pinwheel_periph.md
Name: pinwheel_periph

Overview:
- Parametrised TileLink-UL slave that replaces the ad-hoc debug register and serial stub in the SoC top level.
- Decodes one address tag and provides N byte-maskable debug/scratch registers, a buffered serial TX channel, a buffered serial RX channel, a status/control register and an RX interrupt.
- Sits on the core data bus next to data_ram.
- Single-cycle registered response, identical in timing to block_ram.

Parameters:
- addr_mask, 32'hF0000000, mask applied to a_address for the select decode.
- addr_tag, 32'hF0000000, tag that selects this block after masking.
- n_debug, 4, number of 32-bit debug registers (1..16).
- tx_depth, 8, TX FIFO depth in bytes (power of two, at least 2).
- rx_depth, 8, RX FIFO depth in bytes (power of two, at least 2).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- tick_reset_in  input  1  synchronous, active-high reset.
- tick_tla  input  tilelink_a  request channel from the core bus.
- bus_tld  output  tilelink_d  registered response channel.
- ser_tx_data  output  8  head byte of the TX FIFO.
- ser_tx_valid  output  1  TX FIFO not empty.
- ser_tx_ready  input  1  consumer accepts a byte when valid and ready are both high.
- ser_rx_data  input  8  incoming byte.
- ser_rx_valid  input  1  incoming byte strobe; there is no backpressure.
- debug_out  output  32  live value of debug register 0.
- irq  output  1  registered: rx_irq_en AND RX FIFO not empty.

Behaviour:
- Reset:
  - All debug registers, FIFO pointers and counts, sticky flags and rx_irq_en clear to 0.
  - bus_tld clears to all-zero, so d_valid=0.
  - Outputs after reset: ser_tx_valid=0, irq=0, debug_out=0.
  - Reset asserted mid-transfer discards FIFO contents and any pending response.
- Select: sel = tla.a_valid && ((a_address & addr_mask) == addr_tag). The block ignores a_ready and always accepts.
- Word offset: off = a_address[7:2].
- Latency: a request selected in cycle N produces d_valid=1 in cycle N+1. In N+1, d_opcode is AccessAckData for Get and AccessAck for Put. d_source echoes the request.
- With no select in cycle N, d_valid=0 in cycle N+1 and d_data holds 0.
- Register map (byte offset within the tag):
  - 0x00+4*i, i<n_debug: debug[i], read/write. Writes honour a_mask per byte.
  - 0x40 TX: a write with a_mask[0]=1 pushes a_data[7:0]. If the FIFO is full, the byte is dropped and tx_ovf is set. Reads return 0.
  - 0x44 RX: a read pops one byte and returns {rx_nonempty, 23'b0, byte}. When empty it returns 0 and does not pop. Writes are ignored.
  - 0x48 STATUS: read returns {rx_count[7:0], tx_count[7:0], 12'b0, rx_irq_en, rx_ovf, tx_ovf, tx_full}. A write of bit1=1 clears tx_ovf, bit2=1 clears rx_ovf, and bit3 loads rx_irq_en.
  - Any other offset, or debug index >= n_debug: reads return 0 and writes have no effect. Both respond with d_error=1.
- TX FIFO:
  - Pop occurs when ser_tx_valid && ser_tx_ready.
  - A push while full is accepted if a pop happens in the same cycle, and the count is unchanged.
  - Push into an empty FIFO makes ser_tx_valid=1 in the next cycle. There is no combinational bypass.
- RX FIFO:
  - Push occurs on ser_rx_valid.
  - Full with no simultaneous bus pop: the byte is dropped and rx_ovf is set.
  - A simultaneous bus pop and rx push when full is legal.
- Pointers wrap modulo depth. Counts are $clog2(depth)+1 bits, zero-extended into the 8-bit STATUS fields.
- Sticky flags: set has priority over a same-cycle software clear.
- Reads return pre-write state, i.e. the state at cycle N before any update in cycle N.

Decomposition:
- constants.sv:
  - PERIPH_OFF_DEBUG/TX/RX/STATUS offsets.
  - STATUS bit positions.
- tilelink.sv: reuse tilelink_a, tilelink_d and the TL opcode enum unchanged.
- Sub-module sync_fifo #(width, depth), instantiated twice:
  - inputs: push, wdata, pop;
  - outputs: rdata (head), empty, full, count;
  - behaviour: push-when-full-with-pop permitted.
- Top-level integration: pinwheel replaces debug_reg/serial_* with one pinwheel_periph instance and muxes its bus_tld.d_data when its select was registered.

Test Plan:
- Reset, then Put 0xDEADBEEF mask 4'b0101 to 0xF0000004 (debug[1]), then Get 0xF0000004 → d_valid high exactly one cycle after each request; read data 0x00AD00EF; d_error=0.
- With ser_tx_ready=0, push bytes 0x01..0x09 to 0xF0000040 → STATUS reads tx_count=8, tx_full=1, tx_ovf=1. Then raise ready → ser_tx_data sequence 0x01..0x08, and ser_tx_valid drops after the 8th byte.
- Write STATUS 0x0000000A → rx_irq_en=1, tx_ovf cleared. Then ser_rx_valid pulse with 0x5A → irq=1 from the next cycle; Get 0xF0000044 returns 0x8000005A, and irq falls after the pop.
- Get 0xF0000044 with RX empty → returns 0x00000000, no pointer movement, rx_count stays 0.
- RX full (8 bytes), and the same cycle carries ser_rx_valid 0x77 and a bus pop → rx_count stays 8, rx_ovf=0, 0x77 is read last. Repeat without the pop → rx_ovf=1.
- Get 0xF0000100 and Get to debug index 5 with n_debug=4 → d_error=1, data 0. Assert tick_reset_in mid-drain → ser_tx_valid=0, STATUS=0 the next cycle.
